// File: rtl/pkt_req_sched.sv
// rtl/pkt_req_sched.sv - read-side scheduler: queues packet-info descriptors and issues credit-bounded read requests
module pkt_req_sched #(
  parameter int PTR_WID  = 9,
  parameter int PIMWID   = 48,
  parameter int REQWID   = 37,
  parameter int QAWID    = 4,
  parameter int MAX_OUTS = 4,
  parameter int MAX_LEN  = 9600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_info_vld,
  output logic              pkt_info_rdy,
  input  logic [PIMWID-1:0] pkt_info_msg,
  output logic              pkt_req_vld,
  input  logic              pkt_req_rdy,
  output logic [REQWID-1:0] pkt_req_msg,
  input  logic              cell_done,
  output logic [7:0]        outs_cnt,
  output logic [QAWID:0]    q_cnt,
  output logic [15:0]       drop_cnt,
  output logic              err_underflow
);

  localparam int DEPTH = 1 << QAWID;
  localparam int EW    = PTR_WID + 19;
  localparam logic [QAWID:0] DEPTH_L    = {1'b1, {QAWID{1'b0}}};
  localparam logic [7:0]     MAX_OUTS_L = 8'(MAX_OUTS);
  localparam logic [15:0]    MAX_LEN_L  = 16'(MAX_LEN);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [EW-1:0]     mem [DEPTH];
  logic [QAWID-1:0]  wr_ptr, rd_ptr;
  logic [EW-1:0]     head, entry;
  logic [15:0]       head_len;
  logic              head_drop, cd_valid, credit_ok, out_free, load, push;
  logic [QAWID:0]    q_cnt_nxt;
  logic [REQWID-1:0] head_msg;
  logic              unused_bits;

  // Queue entries keep only {chn, len, ptr}; the rest of the descriptor is not forwarded.
  assign entry       = {pkt_info_msg[27:25], pkt_info_msg[24:9], pkt_info_msg[PTR_WID-1:0]};
  assign unused_bits = ^pkt_info_msg[PIMWID-1:28];

  assign head      = mem[rd_ptr];
  assign head_len  = head[PTR_WID +: 16];
  assign head_drop = (head_len == 16'd0) || (head_len > MAX_LEN_L);

  // A cell_done in this cycle frees a slot early enough to load at this edge.
  assign cd_valid  = cell_done && (outs_cnt != 8'd0);
  assign credit_ok = (outs_cnt < MAX_OUTS_L) || cd_valid;
  assign out_free  = (state == IDLE) || pkt_req_rdy;
  assign load      = (q_cnt != '0) && out_free && (head_drop || credit_ok);
  assign push      = pkt_info_vld && pkt_info_rdy;
  assign q_cnt_nxt = q_cnt + (QAWID+1)'(push) - (QAWID+1)'(load);

  always_comb begin
    head_msg                = '0;
    head_msg[PTR_WID-1:0]   = head[PTR_WID-1:0];
    head_msg[24:9]          = head_len;
    head_msg[27:25]         = head[EW-1 -: 3];
    head_msg[28]            = head_drop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pkt_req_vld   <= 1'b0;
      pkt_req_msg   <= '0;
      pkt_info_rdy  <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_cnt         <= '0;
      outs_cnt      <= '0;
      drop_cnt      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      q_cnt        <= q_cnt_nxt;
      pkt_info_rdy <= (q_cnt_nxt < DEPTH_L);

      if (load) begin
        state       <= HOLD;
        pkt_req_vld <= 1'b1;
        pkt_req_msg <= head_msg;
      end else if (state == HOLD && pkt_req_rdy) begin
        state       <= IDLE;
        pkt_req_vld <= 1'b0;
      end

      // Credit is reserved at load time, not at the request handshake.
      case ({load && !head_drop, cd_valid})
        2'b10:   outs_cnt <= outs_cnt + 8'd1;
        2'b01:   outs_cnt <= outs_cnt - 8'd1;
        default: outs_cnt <= outs_cnt;
      endcase

      if (cell_done && outs_cnt == 8'd0) err_underflow <= 1'b1;

      if (pkt_req_vld && pkt_req_rdy && pkt_req_msg[28] && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pkt_req_sched.sv
// tb/tb_pkt_req_sched.sv - randomized and directed bench for pkt_req_sched against a queue-based model
module tb_pkt_req_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_info_vld;
  logic        pkt_info_rdy;
  logic [47:0] pkt_info_msg;
  logic        pkt_req_vld;
  logic        pkt_req_rdy;
  logic [36:0] pkt_req_msg;
  logic        cell_done;
  logic [7:0]  outs_cnt;
  logic [4:0]  q_cnt;
  logic [15:0] drop_cnt;
  logic        err_underflow;

  pkt_req_sched dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_info_vld(pkt_info_vld), .pkt_info_rdy(pkt_info_rdy), .pkt_info_msg(pkt_info_msg),
    .pkt_req_vld(pkt_req_vld), .pkt_req_rdy(pkt_req_rdy), .pkt_req_msg(pkt_req_msg),
    .cell_done(cell_done), .outs_cnt(outs_cnt), .q_cnt(q_cnt),
    .drop_cnt(drop_cnt), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: every accepted descriptor in order; the front is the one held in the output register when vld=1.
  logic [27:0] exp_q[$];
  int nd_hs  = 0;
  int m_done = 0;
  int m_drops = 0;
  logic m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_drop(input logic [27:0] d);
    int len = int'(d[24:9]);
    return (len == 0) || (len > 9600);
  endfunction

  function automatic logic [36:0] exp_msg(input logic [27:0] d);
    return {8'h00, is_drop(d), d[27:25], d[24:9], d[8:0]};
  endfunction

  function automatic int model_outs();
    int held = (pkt_req_vld && exp_q.size() > 0 && !is_drop(exp_q[0])) ? 1 : 0;
    return nd_hs + held - m_done;
  endfunction

  function automatic logic [27:0] mk(input int ptr, input int len, input int chn);
    logic [27:0] d;
    d = {3'(chn), 16'(len), 9'(ptr)};
    return d;
  endfunction

  function automatic logic [27:0] rand_desc();
    int len;
    case ($urandom % 8)
      0: len = 0;
      1: len = 9600;
      2: len = 9601 + int'($urandom_range(0, 50000));
      default: len = int'($urandom_range(1, 9600));
    endcase
    return mk(int'($urandom_range(0, 511)), len, int'($urandom_range(0, 7)));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    nd_hs = 0; m_done = 0; m_drops = 0; m_err = 1'b0;
  endtask

  // Checks the current outputs, applies one cycle of inputs, updates the model, advances to the next negedge.
  task automatic do_cycle(input logic iv, input logic [27:0] d, input logic rr, input logic cd,
                          output logic pushed);
    int eo;
    eo = model_outs();
    chk("outs_cnt", outs_cnt, eo);
    chk("q_cnt", q_cnt, exp_q.size() - int'(pkt_req_vld));
    chk("info_rdy", pkt_info_rdy, (exp_q.size() - int'(pkt_req_vld)) < 16);
    chk("drop_cnt", drop_cnt, m_drops);
    chk("err_underflow", err_underflow, m_err);
    if (pkt_req_vld) begin
      if (exp_q.size() == 0) chk("req_vld_unexpected", pkt_req_vld, 0);
      else chk("req_msg", pkt_req_msg, exp_msg(exp_q[0]));
    end
    pkt_info_vld = iv;
    pkt_info_msg = {20'($urandom), d};
    pkt_req_rdy  = rr;
    cell_done    = cd;
    pushed = iv && pkt_info_rdy;
    if (pkt_req_vld && rr && exp_q.size() != 0) begin
      if (is_drop(exp_q[0])) m_drops = (m_drops == 65535) ? 65535 : m_drops + 1;
      else nd_hs++;
      void'(exp_q.pop_front());
    end
    if (cd) begin
      if (eo > 0) m_done++;
      else m_err = 1'b1;
    end
    if (pushed) exp_q.push_back(d);
    @(negedge clk);
    pkt_info_vld = 1'b0;
    cell_done    = 1'b0;
  endtask

  task automatic drain();
    logic p;
    int guard = 0;
    while ((model_outs() != 0 || exp_q.size() != 0) && guard < 200) begin
      do_cycle(1'b0, 28'h0, 1'b1, model_outs() != 0, p);
      guard++;
    end
    chk("drain_timeout", guard < 200, 1);
  endtask

  logic p;
  int acc, guard;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pkt_info_vld = 1'b0; pkt_info_msg = '0; pkt_req_rdy = 1'b0; cell_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_info_rdy", pkt_info_rdy, 0);
    chk("rst_req_vld", pkt_req_vld, 0);
    chk("rst_req_msg", pkt_req_msg, 0);
    chk("rst_outs", outs_cnt, 0);
    chk("rst_q", q_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err_underflow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", pkt_info_rdy, 1);

    // Single descriptor latency: vld at cycle 2.
    do_cycle(1'b1, mk(5, 64, 2), 1'b1, 1'b0, p);
    chk("lat_c1_vld", pkt_req_vld, 0);
    do_cycle(1'b0, 28'h0, 1'b1, 1'b0, p);
    chk("lat_c2_vld", pkt_req_vld, 1);
    chk("lat_c2_msg", pkt_req_msg, {8'h00, 1'b0, 3'd2, 16'd64, 9'h005});
    chk("lat_c2_outs", outs_cnt, 1);
    drain();

    // Credit exhaustion and release by cell_done.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, mk(16 + i, 100 + i, 1), 1'b1, 1'b0, p);
    repeat (6) do_cycle(1'b0, 28'h0, 1'b1, 1'b0, p);
    chk("credit_block_vld", pkt_req_vld, 0);
    chk("credit_block_outs", outs_cnt, 4);
    chk("credit_block_q", q_cnt, 1);
    do_cycle(1'b0, 28'h0, 1'b1, 1'b1, p);
    chk("credit_release_vld", pkt_req_vld, 1);
    chk("credit_release_outs", outs_cnt, 4);
    drain();

    // Length classification at the boundaries.
    do_cycle(1'b1, mk(1, 0, 0), 1'b1, 1'b0, p);
    do_cycle(1'b1, mk(2, 9601, 0), 1'b1, 1'b0, p);
    do_cycle(1'b1, mk(3, 9600, 0), 1'b1, 1'b0, p);
    repeat (5) do_cycle(1'b0, 28'h0, 1'b1, 1'b0, p);
    chk("len_drop_cnt", drop_cnt, 2);
    chk("len_outs", outs_cnt, 1);
    drain();

    // Fill the queue while the output is stalled, then release.
    acc = 0; guard = 0;
    while (acc < 17 && guard < 60) begin
      do_cycle(1'b1, mk(acc, 0, acc % 8), 1'b0, 1'b0, p);
      if (p) acc++;
      guard++;
    end
    do_cycle(1'b0, 28'h0, 1'b0, 1'b0, p);
    chk("full_accepted", acc, 17);
    chk("full_q", q_cnt, 16);
    chk("full_rdy", pkt_info_rdy, 0);
    chk("full_vld", pkt_req_vld, 1);
    repeat (20) do_cycle(1'b0, 28'h0, 1'b1, 1'b0, p);
    chk("full_drain_q", q_cnt, 0);
    chk("full_drop_cnt", drop_cnt, 19);
    drain();

    // Underflow.
    chk("pre_underflow_err", err_underflow, 0);
    do_cycle(1'b0, 28'h0, 1'b1, 1'b1, p);
    chk("underflow_err", err_underflow, 1);
    chk("underflow_outs", outs_cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++)
      do_cycle(($urandom % 3) != 0, rand_desc(), ($urandom % 4) != 0, ($urandom % 4) == 0, p);
    drain();

    // Reset while holding a request with three queued.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, mk(40 + i, 200, 3), 1'b0, 1'b0, p);
    repeat (3) do_cycle(1'b0, 28'h0, 1'b0, 1'b0, p);
    chk("hold_vld", pkt_req_vld, 1);
    chk("hold_q", q_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", pkt_req_vld, 0);
    chk("mid_rst_msg", pkt_req_msg, 0);
    chk("mid_rst_rdy", pkt_info_rdy, 0);
    chk("mid_rst_outs", outs_cnt, 0);
    chk("mid_rst_q", q_cnt, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_err", err_underflow, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_mid_reset", pkt_info_rdy, 1);
    do_cycle(1'b1, mk(7, 300, 4), 1'b1, 1'b0, p);
    repeat (3) do_cycle(1'b0, 28'h0, 1'b1, 1'b0, p);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
